// File: rtl/ak_arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the serial units and
// the 1-bit borrow/carry cell equations used by the subtractor and adder family.
package ak_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic sub_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

    function automatic logic add_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic add_carry(input logic a, input logic b, input logic cin);
        return (a & b) | ((a ^ b) & cin);
    endfunction

endpackage

// File: rtl/ak_1bit_sub.sv
// Purely combinational 1-bit full-subtractor cell; counterpart of the 1-bit
// full-adder cell.
module ak_1bit_sub
    import ak_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = sub_diff(a, b, bin);
    assign bout = sub_borrow(a, b, bin);

endmodule

// File: rtl/ak_serial_sub.sv
// Bit-serial unsigned subtractor: A - B - B0, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module ak_serial_sub
    import ak_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ankit_diff,
    output logic             BW
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
    logic             borrow;
    logic             cell_d, cell_bout;
    logic             accept;

    ak_1bit_sub u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (count == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers are cleared by reset so the result outputs read
    // zero while reset is asserted and after an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= B0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    diff_sh <= {cell_d, diff_sh[WIDTH-1:1]};
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    borrow  <= cell_bout;
                    count   <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers are left untouched outside CALC, so the outputs hold
    // from DONE entry until the next accept.
    assign ankit_diff = diff_sh;
    assign BW         = borrow;

endmodule

// File: tb/tb_ak_serial_sub.sv
// Directed and exhaustive/random bench for ak_serial_sub at WIDTH=4 and WIDTH=8.
module tb_ak_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel8;
    logic       iv, ordy;
    logic [7:0] a_in, b_in;
    logic       b0_in;

    logic       ir4, ov4, bw4;
    logic [3:0] d4;
    logic       ir8, ov8, bw8;
    logic [7:0] d8;

    logic       ir, ov, bw_m;
    logic [7:0] diff_m;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ak_serial_sub #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv & ~sel8),
        .in_ready   (ir4),
        .A          (a_in[3:0]),
        .B          (b_in[3:0]),
        .B0         (b0_in),
        .out_valid  (ov4),
        .out_ready  (ordy & ~sel8),
        .ankit_diff (d4),
        .BW         (bw4)
    );

    ak_serial_sub #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv & sel8),
        .in_ready   (ir8),
        .A          (a_in),
        .B          (b_in),
        .B0         (b0_in),
        .out_valid  (ov8),
        .out_ready  (ordy & sel8),
        .ankit_diff (d8),
        .BW         (bw8)
    );

    assign ir     = sel8 ? ir8 : ir4;
    assign ov     = sel8 ? ov8 : ov4;
    assign bw_m   = sel8 ? bw8 : bw4;
    assign diff_m = sel8 ? d8 : {4'b0, d4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic b0);
        a_in  = a;
        b_in  = b;
        b0_in = b0;
        iv    = 1'b1;
        tick();
        iv    = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!ov && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input logic b0, input int stall, input string tag);
        logic [8:0] full;
        logic [7:0] mask;
        int         cyc;
        sel8 = w8;
        mask = w8 ? 8'hFF : 8'h0F;
        full = {1'b0, a & mask} - {1'b0, b & mask} - {8'b0, b0};
        check({tag, " in_ready"}, ir, 1);
        start_op(a & mask, b & mask, b0);
        wait_valid(cyc);
        check({tag, " latency"}, cyc, w8 ? 8 : 4);
        repeat (stall) tick();
        check({tag, " out_valid"}, ov, 1);
        check({tag, " diff"}, diff_m, full[7:0] & mask);
        check({tag, " BW"}, bw_m, full[8]);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        check({tag, " idle"}, ov, 0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        sel8  = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        b0_in = 1'b0;
        #1;
        check("rst in_ready", ir, 1);
        check("rst out_valid", ov, 0);
        check("rst diff", diff_m, 0);
        check("rst BW", bw_m, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post-rst in_ready", ir, 1);
        check("post-rst out_valid", ov, 0);
        check("post-rst diff", diff_m, 0);

        // T1/T2 directed vectors
        run_op(1'b0, 8'h9, 8'h3, 1'b0, 0, "T1 9-3");
        run_op(1'b0, 8'h3, 8'h9, 1'b0, 0, "T2 3-9");
        run_op(1'b0, 8'h0, 8'h0, 1'b1, 0, "T2 0-0-1");
        run_op(1'b0, 8'hF, 8'hF, 1'b1, 0, "T2 F-F-1");
        run_op(1'b0, 8'h5, 8'h5, 1'b0, 0, "T2 5-5");

        // T3 backpressure: C-5 = 7, no borrow
        start_op(8'hC, 8'h5, 1'b0);
        wait_valid(cyc);
        check("T3 latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            iv   = 1'b1;
            a_in = 8'h1;
            b_in = 8'h1;
            tick();
            check("T3 hold out_valid", ov, 1);
            check("T3 hold in_ready", ir, 0);
            check("T3 hold diff", diff_m, 8'h7);
            check("T3 hold BW", bw_m, 0);
        end
        iv   = 1'b0;
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        check("T3 release in_ready", ir, 1);
        check("T3 release out_valid", ov, 0);
        check("T3 release diff held", diff_m, 8'h7);

        // T4 operands change after accept: E-3-1 = A
        start_op(8'hE, 8'h3, 1'b1);
        a_in  = 8'h0;
        b_in  = 8'hF;
        b0_in = 1'b0;
        wait_valid(cyc);
        check("T4 latency", cyc, 4);
        check("T4 diff", diff_m, 8'hA);
        check("T4 BW", bw_m, 0);
        ordy = 1'b1;
        tick();
        ordy = 1'b0;

        // T5 reset mid-CALC at count=2
        start_op(8'h9, 8'h3, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("T5 in_ready", ir, 1);
        check("T5 out_valid", ov, 0);
        check("T5 diff", diff_m, 0);
        check("T5 BW", bw_m, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_op(1'b0, 8'h7, 8'h2, 1'b1, 0, "T5 after");

        // T6 exhaustive at WIDTH=4 with random stalls
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            run_op(1'b0, {4'b0, vv[3:0]}, {4'b0, vv[7:4]}, vv[8],
                   int'($urandom_range(0, 2)), "T6 w4");
        end

        // T6 random at WIDTH=8 with random stalls
        for (int k = 0; k < 300; k++) begin
            run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "T6 w8");
        end
        run_op(1'b1, 8'h00, 8'hFF, 1'b1, 0, "T6 w8 min");
        run_op(1'b1, 8'hFF, 8'h00, 1'b0, 0, "T6 w8 max");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
